// File: rtl/uart_rx_packet.sv
// Packet framer behind a UART receiver: decodes SYNC, LEN, payload, CHK frames
// into a held buffer with a valid/ack release, plus error and overrun pulses.
module uart_rx_packet #(
   parameter int         MAX_LEN      = 16,
   parameter logic [7:0] SYNC_BYTE    = 8'hA5,
   parameter int         TIMEOUT_CLKS = 2000
) (
   input  logic       i_Clock,
   input  logic       i_Rst_n,
   input  logic       i_Rx_DV,
   input  logic [7:0] i_Rx_Byte,
   input  logic       i_Pkt_Ack,
   input  logic [7:0] i_Rd_Addr,
   output logic       o_Pkt_Valid,
   output logic [7:0] o_Pkt_Len,
   output logic [7:0] o_Rd_Data,
   output logic       o_Err,
   output logic [1:0] o_Err_Code,
   output logic       o_Overrun
);

   localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int          DEPTH     = 1 << AW;
   localparam logic [15:0] TOUT_LAST = 16'(TIMEOUT_CLKS - 1);
   localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CHK, S_HOLD} state_t;

   state_t      r_State;
   state_t      w_Next;
   logic [7:0]  r_Len;
   logic [7:0]  r_Sum;
   logic [7:0]  r_Idx;
   logic [15:0] r_Cnt;
   logic [7:0]  r_Buf [0:DEPTH-1];

   logic        w_Timed;
   logic        w_Tout;
   logic        w_Len_Ok;
   logic        w_Pay_We;
   logic        w_Chk_Ok;
   logic        w_Err;
   logic [1:0]  w_Err_Code;
   logic        w_Ovr;

   assign w_Timed = (r_State == S_LEN) || (r_State == S_PAYLOAD) || (r_State == S_CHK);
   assign w_Tout  = w_Timed && !i_Rx_DV && (r_Cnt == TOUT_LAST);

   // Handshake: o_Pkt_Valid is high from the edge after a matching CHK byte until
   // i_Pkt_Ack is sampled; a byte arriving with the ack is decoded as an IDLE byte.
   always_comb begin
      w_Next     = r_State;
      w_Len_Ok   = 1'b0;
      w_Pay_We   = 1'b0;
      w_Chk_Ok   = 1'b0;
      w_Err      = 1'b0;
      w_Err_Code = o_Err_Code;
      w_Ovr      = 1'b0;
      case (r_State)
         S_IDLE: begin
            if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) w_Next = S_LEN;
         end
         S_LEN: begin
            if (i_Rx_DV) begin
               if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > MAX_LEN_B)) begin
                  w_Err      = 1'b1;
                  w_Err_Code = 2'b01;
                  w_Next     = S_IDLE;
               end else begin
                  w_Len_Ok = 1'b1;
                  w_Next   = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (i_Rx_DV) begin
               w_Pay_We = 1'b1;
               if (r_Idx == (r_Len - 8'd1)) w_Next = S_CHK;
            end
         end
         S_CHK: begin
            if (i_Rx_DV) begin
               if (i_Rx_Byte == r_Sum) begin
                  w_Chk_Ok = 1'b1;
                  w_Next   = S_HOLD;
               end else begin
                  w_Err      = 1'b1;
                  w_Err_Code = 2'b10;
                  w_Next     = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            if (i_Pkt_Ack) begin
               w_Next = (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) ? S_LEN : S_IDLE;
            end else if (i_Rx_DV) begin
               w_Ovr = 1'b1;
            end
         end
         default: w_Next = S_IDLE;
      endcase
      if (w_Tout) begin
         w_Err      = 1'b1;
         w_Err_Code = 2'b11;
         w_Next     = S_IDLE;
      end
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) r_State <= S_IDLE;
      else          r_State <= w_Next;
   end

   always_ff @(posedge i_Clock or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         r_Len      <= 8'd0;
         r_Sum      <= 8'd0;
         r_Idx      <= 8'd0;
         r_Cnt      <= 16'd0;
         o_Pkt_Len  <= 8'd0;
         o_Rd_Data  <= 8'd0;
         o_Err      <= 1'b0;
         o_Err_Code <= 2'b00;
         o_Overrun  <= 1'b0;
      end else begin
         // Idle counter restarts on any byte and on every state change.
         if (!w_Timed || i_Rx_DV || (w_Next != r_State)) r_Cnt <= 16'd0;
         else                                            r_Cnt <= r_Cnt + 16'd1;
         if (w_Len_Ok) begin
            r_Len <= i_Rx_Byte;
            r_Sum <= i_Rx_Byte;
            r_Idx <= 8'd0;
         end
         if (w_Pay_We) begin
            r_Sum <= r_Sum + i_Rx_Byte;
            r_Idx <= r_Idx + 8'd1;
         end
         if (w_Chk_Ok) o_Pkt_Len <= r_Len;
         o_Err      <= w_Err;
         o_Err_Code <= w_Err_Code;
         o_Overrun  <= w_Ovr;
         o_Rd_Data  <= (i_Rd_Addr < o_Pkt_Len) ? r_Buf[i_Rd_Addr[AW-1:0]] : 8'h00;
      end
   end

   always_ff @(posedge i_Clock) begin
      if (w_Pay_We) r_Buf[r_Idx[AW-1:0]] <= i_Rx_Byte;
   end

   assign o_Pkt_Valid = (r_State == S_HOLD);

endmodule

// File: tb/tb_uart_rx_packet.sv
// Randomised bench for uart_rx_packet: a byte-level frame model fills an expected
// event queue that a negedge monitor drains as the DUT reports packets and errors.
module tb_uart_rx_packet;

   localparam int         MAX_LEN = 16;
   localparam int         TOUT    = 64;
   localparam logic [7:0] SYNC    = 8'hA5;
   localparam int         W       = 12;
   localparam int         K_PKT   = 0;
   localparam int         K_ERR   = 1;
   localparam int         K_OVR   = 2;

   logic       i_Clock   = 1'b0;
   logic       i_Rst_n   = 1'b1;
   logic       i_Rx_DV   = 1'b0;
   logic [7:0] i_Rx_Byte = 8'h00;
   logic       i_Pkt_Ack = 1'b0;
   logic [7:0] i_Rd_Addr = 8'h00;
   logic       o_Pkt_Valid;
   logic [7:0] o_Pkt_Len;
   logic [7:0] o_Rd_Data;
   logic       o_Err;
   logic [1:0] o_Err_Code;
   logic       o_Overrun;

   uart_rx_packet #(.MAX_LEN(MAX_LEN), .SYNC_BYTE(SYNC), .TIMEOUT_CLKS(TOUT)) dut (
      .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
      .i_Pkt_Ack(i_Pkt_Ack), .i_Rd_Addr(i_Rd_Addr), .o_Pkt_Valid(o_Pkt_Valid),
      .o_Pkt_Len(o_Pkt_Len), .o_Rd_Data(o_Rd_Data), .o_Err(o_Err),
      .o_Err_Code(o_Err_Code), .o_Overrun(o_Overrun)
   );

   // ---------------- clock / watchdog ----------------
   always #5 i_Clock = ~i_Clock;

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int         checks   = 0;
   int         failures = 0;
   int         rd_count = 0;
   bit         done     = 1'b0;
   logic [W-1:0] exp_q[$];        // {len[7:0], code[1:0], kind[1:0]}
   logic [7:0]   exp_data_q[$];
   logic [7:0]   seq_q[$];

   function automatic void chk(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endfunction

   function automatic void push_exp(input int kind, input int code, input int len);
      exp_q.push_back({8'(len), 2'(code), 2'(kind)});
   endfunction

   // ---------------- reference model (frame level) ----------------
   int         m_phase = 0;      // 0 hunt, 1 length, 2 payload, 3 checksum, 4 held
   int         m_len   = 0;
   int         m_sum   = 0;
   int         m_idle  = 0;
   logic [7:0] m_pay[$];

   function automatic void model_byte(input logic [7:0] b, input bit ack);
      if (m_phase == 4) begin
         if (ack) m_phase = 0;
         else begin
            push_exp(K_OVR, 0, 0);
            return;
         end
      end
      case (m_phase)
         0: if (b == SYNC) m_phase = 1;
         1: begin
            if (b == 8'd0 || int'(b) > MAX_LEN) begin
               push_exp(K_ERR, 1, 0);
               m_phase = 0;
            end else begin
               m_len = int'(b);
               m_sum = int'(b);
               m_pay.delete();
               m_phase = 2;
            end
         end
         2: begin
            m_pay.push_back(b);
            m_sum = (m_sum + int'(b)) % 256;
            if (m_pay.size() == m_len) m_phase = 3;
         end
         3: begin
            if (int'(b) == m_sum) begin
               push_exp(K_PKT, 0, m_len);
               foreach (m_pay[i]) exp_data_q.push_back(m_pay[i]);
               m_phase = 4;
            end else begin
               push_exp(K_ERR, 2, 0);
               m_phase = 0;
            end
         end
         default: m_phase = 0;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick_idle();
      @(posedge i_Clock); #1;
      i_Rx_DV   = 1'b0;
      i_Pkt_Ack = 1'b0;
      m_idle++;
      if (m_phase >= 1 && m_phase <= 3 && m_idle == TOUT) begin
         push_exp(K_ERR, 3, 0);
         m_phase = 0;
      end
   endtask

   task automatic drive_byte(input logic [7:0] b, input bit ack);
      @(posedge i_Clock); #1;
      i_Rx_DV   = 1'b1;
      i_Rx_Byte = b;
      i_Pkt_Ack = ack;
      m_idle    = 0;
      model_byte(b, ack);
   endtask

   task automatic ack_only();
      @(posedge i_Clock); #1;
      i_Rx_DV   = 1'b0;
      i_Pkt_Ack = 1'b1;
      m_idle++;
      if (m_phase == 4) m_phase = 0;
   endtask

   function automatic int rgap();
      return ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 8)) : int'($urandom_range(0, 2));
   endfunction

   function automatic bit rack(input bit en);
      return en && ($urandom_range(0, 7) == 0);
   endfunction

   task automatic send(input logic [7:0] b, input int gap, input bit ack);
      repeat (gap) tick_idle();
      drive_byte(b, ack);
   endtask

   task automatic send_seq(input int gap);
      while (seq_q.size() > 0) send(seq_q.pop_front(), gap, 1'b0);
   endtask

   task automatic send_body(input int len, input bit good, input bit ra);
      int sum;
      logic [7:0] b;
      send(8'(len), rgap(), rack(ra));
      sum = len;
      for (int i = 0; i < len; i++) begin
         b = 8'($urandom_range(0, 255));
         sum += int'(b);
         send(b, rgap(), rack(ra));
      end
      send(8'(good ? sum % 256 : (sum + 1) % 256), rgap(), rack(ra));
   endtask

   // mode 0: plain ack, 1: ack together with SYNC, 2: ack with a non-sync byte
   task automatic service_hold(input int n_ovr, input int mode);
      int seen;
      int guard;
      logic [7:0] b;
      seen = rd_count;
      for (int i = 0; i < n_ovr; i++) begin
         b = (i == 0) ? 8'h55 : 8'($urandom_range(0, 255));
         send(b, $urandom_range(0, 2), 1'b0);
      end
      tick_idle();
      guard = 0;
      while (rd_count == seen && guard < 400) begin
         tick_idle();
         guard++;
      end
      if (mode == 1) drive_byte(SYNC, 1'b1);
      else if (mode == 2) drive_byte(8'h3C, 1'b1);
      else ack_only();
   endtask

   task automatic good_frame(input bit ra);
      send(SYNC, rgap(), rack(ra));
      send_body($urandom_range(1, MAX_LEN), 1'b1, ra);
      if (m_phase == 4) service_hold($urandom_range(0, 2), 0);
   endtask

   task automatic do_reset();
      @(posedge i_Clock); #1;
      i_Rx_DV   = 1'b0;
      i_Pkt_Ack = 1'b0;
      i_Rst_n   = 1'b0;
      m_phase   = 0;
      m_idle    = 0;
      repeat (2) @(posedge i_Clock);
      #1 i_Rst_n = 1'b1;
   endtask

   // ---------------- stimulus ----------------
   initial begin : driver
      int kind;
      #2 i_Rst_n = 1'b0;
      repeat (3) @(posedge i_Clock);
      #1 i_Rst_n = 1'b1;
      repeat (2) tick_idle();

      seq_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
      send_seq(0);
      service_hold(1, 0);

      seq_q = '{8'hA5, 8'h00};
      send_seq(1);
      good_frame(1'b0);
      seq_q = '{8'hA5, 8'h11};
      send_seq(0);
      good_frame(1'b0);
      seq_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
      send_seq(0);
      good_frame(1'b0);

      seq_q = '{8'hA5, 8'h02, 8'h10};
      send_seq(0);
      repeat (TOUT + 5) tick_idle();
      good_frame(1'b0);

      send(SYNC, 0, 1'b0);
      send_body(4, 1'b1, 1'b0);
      service_hold(0, 1);
      send_body(2, 1'b1, 1'b0);
      service_hold(2, 0);

      send(SYNC, 0, 1'b0);
      send(8'(MAX_LEN), 0, 1'b0);
      repeat (MAX_LEN) send(8'hFF, 0, 1'b0);
      send(8'(((MAX_LEN) + MAX_LEN * 255) % 256), 0, 1'b0);
      service_hold(0, 0);

      seq_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
      send_seq(0);
      service_hold(0, 2);

      seq_q = '{8'hA5, 8'h04, 8'h01, 8'h02};
      send_seq(0);
      do_reset();
      good_frame(1'b0);

      for (int n = 0; n < 150; n++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 5) begin
            send(SYNC, rgap(), 1'b0);
            send_body($urandom_range(1, MAX_LEN), 1'b1, 1'b1);
         end else if (kind == 6) begin
            send(SYNC, rgap(), 1'b0);
            send(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)), rgap(), 1'b0);
         end else if (kind == 7) begin
            send(SYNC, rgap(), 1'b0);
            send_body($urandom_range(1, MAX_LEN), 1'b0, 1'b1);
         end else if (kind == 8) begin
            repeat ($urandom_range(1, 4)) send((8'($urandom_range(0, 255)) == SYNC) ? 8'h00 : 8'($urandom_range(0, 254)) & 8'hF7, rgap(), rack(1'b1));
            send(SYNC, rgap(), 1'b0);
            send_body($urandom_range(1, MAX_LEN), 1'b1, 1'b0);
         end else begin
            send(SYNC, rgap(), 1'b0);
            send_body($urandom_range(1, MAX_LEN), 1'b1, 1'b0);
            service_hold($urandom_range(0, 2), 1);
            send_body($urandom_range(1, MAX_LEN), 1'b1, 1'b0);
         end
         if (m_phase == 4) service_hold($urandom_range(0, 2), 2 * $urandom_range(0, 1));
      end

      repeat (6) tick_idle();
      done = 1'b1;
   end

   // ---------------- monitor ----------------
   initial begin : monitor
      bit           prev_v;
      bit           ack_pend;
      bit           rd_active;
      int           rd_i;
      int           rd_len;
      int           a;
      logic [1:0]   last_code;
      logic [7:0]   rd_exp [0:255];
      logic [W-1:0] e;
      prev_v = 0; ack_pend = 0; rd_active = 0; rd_i = 0; rd_len = 0; last_code = 2'b00;
      while (!done) begin
         @(negedge i_Clock);
         if (!i_Rst_n) begin
            chk({o_Pkt_Valid, o_Pkt_Len, o_Rd_Data, o_Err, o_Err_Code, o_Overrun} == '0, "reset_values",
                {o_Pkt_Valid, o_Pkt_Len, o_Rd_Data, o_Err, o_Err_Code, o_Overrun}, 0);
            prev_v = 0; ack_pend = 0; rd_active = 0; last_code = 2'b00;
         end else begin
            if (ack_pend) chk(o_Pkt_Valid == 1'b0, "ack_clears_valid", o_Pkt_Valid, 0);
            ack_pend = 0;
            if (o_Err) begin
               if (exp_q.size() == 0) chk(1'b0, "unexpected_err", o_Err_Code, 0);
               else begin
                  e = exp_q.pop_front();
                  chk(e[1:0] == 2'(K_ERR), "err_event_kind", K_ERR, e[1:0]);
                  chk(o_Err_Code == e[3:2], "err_code", o_Err_Code, e[3:2]);
                  last_code = e[3:2];
               end
            end else begin
               chk(o_Err_Code == last_code, "err_code_hold", o_Err_Code, last_code);
            end
            if (o_Overrun) begin
               if (exp_q.size() == 0) chk(1'b0, "unexpected_overrun", 1, 0);
               else begin
                  e = exp_q.pop_front();
                  chk(e[1:0] == 2'(K_OVR), "overrun_event_kind", K_OVR, e[1:0]);
               end
            end
            if (o_Pkt_Valid && !prev_v) begin
               if (exp_q.size() == 0) chk(1'b0, "unexpected_pkt", o_Pkt_Len, 0);
               else begin
                  e = exp_q.pop_front();
                  chk(e[1:0] == 2'(K_PKT), "pkt_event_kind", K_PKT, e[1:0]);
                  if (e[1:0] == 2'(K_PKT)) begin
                     chk(o_Pkt_Len == e[11:4], "pkt_len", o_Pkt_Len, e[11:4]);
                     rd_len = int'(e[11:4]);
                     for (int i = 0; i < rd_len; i++)
                        rd_exp[i] = (exp_data_q.size() > 0) ? exp_data_q.pop_front() : 8'h00;
                     rd_active = 1;
                     rd_i      = 0;
                  end
               end
            end
            if (rd_active) begin
               if (rd_i > 0) begin
                  a = (rd_i - 1 <= rd_len) ? rd_i - 1 : 255;
                  chk(o_Rd_Data == ((a < rd_len) ? rd_exp[a] : 8'h00), "rd_data",
                      o_Rd_Data, (a < rd_len) ? rd_exp[a] : 8'h00);
               end
               if (rd_i < rd_len + 2) begin
                  i_Rd_Addr = 8'((rd_i <= rd_len) ? rd_i : 255);
                  rd_i++;
               end else begin
                  rd_active = 0;
                  rd_count++;
               end
            end
            if (o_Pkt_Valid && i_Pkt_Ack) ack_pend = 1;
            prev_v = o_Pkt_Valid;
         end
      end
      chk(exp_q.size() == 0, "events_outstanding", exp_q.size(), 0);
      chk(exp_data_q.size() == 0, "data_outstanding", exp_data_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
